unitate_pc: RTL and testbench

Parametrised program-counter unit for the RISC-8 core: holds the architectural PC register and computes the next fetch address. It supports jumps, conditional branches with selectable condition, stall, and call/return through an internal return-address stack (RAS). It sits between the control decoder/ALU and the instruction memory address port. It supersedes the purely combinational next-PC logic.

---
 rtl/unitate_pc.sv | 191 +++++++++++++++++++
 tb/tb_unitate_pc.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/unitate_pc.sv
// unitate_pc -- program-counter unit for the RISC-8 core.
// Holds the architectural PC and computes the next fetch address from
// jump / conditional branch / call / return requests, with stall support.
// Optional feature macro: PC_RAS_EN. When defined, a circular return-address
// stack (RAS) backs call/ret and drives the ras_* status outputs. When not
// defined, call behaves as jump, ret is ignored and the ras_* outputs are
// tied to their idle values.

module unitate_pc #(
  parameter int PC_W      = 8,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               stall,
  input  logic                               jump,
  input  logic                               branch,
  input  logic [1:0]                         br_mode,
  input  logic                               alu_zero,
  input  logic                               alu_neg,
  input  logic                               call,
  input  logic                               ret,
  input  logic [PC_W-1:0]                    immediate,
  output logic [PC_W-1:0]                    pc,
  output logic [PC_W-1:0]                    next_pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count,
  output logic                               ras_full,
  output logic                               ras_empty,
  output logic                               ras_err
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  // Branch condition decode: EQ, NE, LT, always.
  function automatic logic branch_cond(input logic [1:0] mode,
                                       input logic       zero,
                                       input logic       neg);
    logic taken;
    case (mode)
      2'b00:   taken = zero;
      2'b01:   taken = ~zero;
      2'b10:   taken = neg;
      2'b11:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_branch;
  logic [PC_W-1:0] w_next_pc;
  logic            w_br_taken;
  logic            w_ret_sel;
  logic [PC_W-1:0] w_ras_top;
  logic            w_ras_empty;

  // Sequential and relative targets; additions wrap modulo 2^PC_W, and the
  // two's-complement offset needs no special handling under that arithmetic.
  assign w_pc_inc    = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign w_pc_branch = r_pc + immediate;
  assign w_br_taken  = branch & branch_cond(br_mode, alu_zero, alu_neg);

`ifdef PC_RAS_EN
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  // Circular pointer step forward, wrapping at RAS_DEPTH-1 (depth need not
  // be a power of two).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] q;
    if (p == PTR_W'(RAS_DEPTH - 1)) begin
      q = {PTR_W{1'b0}};
    end else begin
      q = p + PTR_W'(1);
    end
    return q;
  endfunction

  // Circular pointer step backward, wrapping at zero.
  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] q;
    if (p == {PTR_W{1'b0}}) begin
      q = PTR_W'(RAS_DEPTH - 1);
    end else begin
      q = p - PTR_W'(1);
    end
    return q;
  endfunction

  // r_wr_ptr is the slot the next push writes. When the stack is full that
  // slot holds the oldest entry, so an overflowing push overwrites it with no
  // extra bookkeeping.
  logic [PC_W-1:0]  r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err;
  logic             w_ras_full;
  logic             w_push;

  assign w_ras_empty = (r_count == {CNT_W{1'b0}});
  assign w_ras_full  = (r_count == CNT_W'(RAS_DEPTH));
  assign w_ras_top   = r_ras[ptr_dec(r_wr_ptr)];
  assign w_ret_sel   = ret;
  // ret outranks call, so a simultaneous call never pushes.
  assign w_push      = ~stall & call & ~ret;

  // RAS storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[r_wr_ptr] <= w_pc_inc;
    end
  end

  // RAS pointer, occupancy and sticky error flag (cleared only by reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
      r_err    <= 1'b0;
    end else if (!stall) begin
      if (ret) begin
        if (!w_ras_empty) begin
          r_wr_ptr <= ptr_dec(r_wr_ptr);
          r_count  <= r_count - CNT_W'(1);
        end
        if (w_ras_empty || call) begin
          r_err <= 1'b1;
        end
      end else if (call) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_ras_full) begin
          r_err <= 1'b1;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign ras_count = r_count;
  assign ras_full  = w_ras_full;
  assign ras_empty = w_ras_empty;
  assign ras_err   = r_err;
`else
  logic w_unused_ret;

  // Without a stack, ret has no effect on the PC at all.
  assign w_unused_ret = ret;
  assign w_ret_sel    = 1'b0;
  assign w_ras_top    = w_pc_inc;
  assign w_ras_empty  = 1'b1;

  assign ras_count = {CNT_W{1'b0}};
  assign ras_full  = 1'b0;
  assign ras_empty = 1'b1;
  assign ras_err   = 1'b0;
`endif

  // Next fetch address, first matching rule wins: ret, call, jump,
  // taken branch, sequential.
  always_comb begin
    w_next_pc = w_pc_inc;
    if (w_ret_sel) begin
      if (w_ras_empty) begin
        w_next_pc = w_pc_inc;
      end else begin
        w_next_pc = w_ras_top;
      end
    end else if (call || jump) begin
      w_next_pc = immediate;
    end else if (w_br_taken) begin
      w_next_pc = w_pc_branch;
    end else begin
      w_next_pc = w_pc_inc;
    end
  end

  // Architectural PC register; held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= PC_W'(RESET_PC);
    end else if (!stall) begin
      r_pc <= w_next_pc;
    end
  end

  assign pc      = r_pc;
  assign next_pc = w_next_pc;

endmodule

// File: tb/tb_unitate_pc.sv
// Testbench for unitate_pc (PC_W=8, RAS_DEPTH=4, RESET_PC=0).
// A table of per-cycle stimulus records carries hand-derived expectations for
// both builds (with and without PC_RAS_EN); expected post-edge state is queued
// when a vector is driven and popped when the edge has happened.

module tb_unitate_pc;

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       stall, jump, branch, alu_zero, alu_neg, call, ret;
  logic [1:0] br_mode;
  logic [7:0] immediate;
  logic [7:0] pc, next_pc;
  logic [2:0] ras_count;
  logic       ras_full, ras_empty, ras_err;

  unitate_pc #(.PC_W(8), .RAS_DEPTH(4), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump), .branch(branch),
    .br_mode(br_mode), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .call(call), .ret(ret), .immediate(immediate),
    .pc(pc), .next_pc(next_pc), .ras_count(ras_count),
    .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rb;       // pulse reset between edges before this vector
    logic       st, jp, br;
    logic [1:0] bm;
    logic       z, ng, ca, re;
    logic [7:0] imm;
    logic [7:0] nx_on;    // next_pc with the RAS built
    logic [2:0] cnt_on;   // ras_count after the edge, RAS built
    logic       err_on;   // ras_err after the edge, RAS built
    logic [7:0] nx_off;   // next_pc without the RAS
  } vec_t;

  typedef struct {
    logic [7:0] pc;
    logic [2:0] cnt;
    logic       err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic rb, st, jp, br, input logic [1:0] bm,
                     input logic z, ng, ca, re, input logic [7:0] imm,
                     input logic [7:0] nx_on, input logic [2:0] cnt_on,
                     input logic err_on, input logic [7:0] nx_off);
    vec_t v;
    v.rb = rb; v.st = st; v.jp = jp; v.br = br; v.bm = bm; v.z = z; v.ng = ng;
    v.ca = ca; v.re = re; v.imm = imm; v.nx_on = nx_on; v.cnt_on = cnt_on;
    v.err_on = err_on; v.nx_off = nx_off;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic check_reset_state(input int idx);
    check("rst_pc", idx, 32'(pc), 32'h0);
    check("rst_count", idx, 32'(ras_count), 32'h0);
    check("rst_empty", idx, 32'(ras_empty), 32'h1);
    check("rst_full", idx, 32'(ras_full), 32'h0);
    check("rst_err", idx, 32'(ras_err), 32'h0);
  endtask

  initial begin
    logic [7:0] exp_pc;
    logic [7:0] exp_nx;
    exp_t       e;
    vec_t       v;

    //  rb st jp br bm    z  n  ca re imm    nx_on cnt err nx_off
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 8'h01); // 1 sequential
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0, 8'h02); // 2
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 8'h03); // 3
    add(0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 8'hFF); // 4 jump FF
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00); // 5 wrap
    add(0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 8'h10, 8'h10, 0, 0, 8'h10); // 6 jump 10
    add(0, 1, 0, 1, 2'd0, 1, 0, 0, 0, 8'hFC, 8'h0C, 0, 0, 8'h0C); // 7 EQ z=1
    add(0, 1, 0, 1, 2'd0, 0, 0, 0, 0, 8'hFC, 8'h11, 0, 0, 8'h11); // 8 EQ z=0
    add(0, 1, 0, 1, 2'd1, 0, 0, 0, 0, 8'hFC, 8'h0C, 0, 0, 8'h0C); // 9 NE z=0
    add(0, 1, 0, 1, 2'd1, 1, 0, 0, 0, 8'hFC, 8'h11, 0, 0, 8'h11); // 10 NE z=1
    add(0, 1, 0, 1, 2'd2, 0, 1, 0, 0, 8'hFC, 8'h0C, 0, 0, 8'h0C); // 11 LT n=1
    add(0, 1, 0, 1, 2'd2, 1, 0, 0, 0, 8'hFC, 8'h11, 0, 0, 8'h11); // 12 LT n=0
    add(0, 1, 0, 1, 2'd3, 0, 0, 0, 0, 8'hFC, 8'h0C, 0, 0, 8'h0C); // 13 always
    add(0, 1, 1, 1, 2'd3, 0, 0, 0, 0, 8'h40, 8'h40, 0, 0, 8'h40); // 14 jump beats branch
    add(0, 0, 0, 1, 2'd2, 0, 1, 0, 0, 8'hFC, 8'h0C, 0, 0, 8'h0C); // 15 LT taken
    add(0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 8'h05, 8'h05, 0, 0, 8'h05); // 16 jump 05
    add(0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 8'h20, 8'h20, 1, 0, 8'h20); // 17 call 20
    add(0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 8'h22, 8'h22, 1, 0, 8'h22); // 18 jump 22
    add(0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 8'h30, 8'h30, 2, 0, 8'h30); // 19 call 30
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 8'h00, 8'h23, 1, 0, 8'h31); // 20 ret
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 8'h00, 8'h06, 0, 0, 8'h32); // 21 ret
    add(0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 8'h40, 8'h40, 1, 0, 8'h40); // 22 call x5
    add(0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 8'h50, 8'h50, 2, 0, 8'h50); // 23
    add(0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 8'h60, 8'h60, 3, 0, 8'h60); // 24
    add(0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 8'h70, 8'h70, 4, 0, 8'h70); // 25 full
    add(0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 8'h80, 8'h80, 4, 1, 8'h80); // 26 overflow
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 8'h00, 8'h71, 3, 1, 8'h81); // 27 ret x5
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 8'h00, 8'h61, 2, 1, 8'h82); // 28
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 8'h00, 8'h51, 1, 1, 8'h83); // 29
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 8'h00, 8'h41, 0, 1, 8'h84); // 30
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 8'h00, 8'h42, 0, 1, 8'h85); // 31 empty ret
    add(0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 8'h10, 8'h10, 1, 1, 8'h10); // 32 fill to 3
    add(0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 8'h20, 8'h20, 2, 1, 8'h20); // 33
    add(0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 8'h30, 8'h30, 3, 1, 8'h30); // 34
    add(1, 0, 0, 0, 2'd0, 0, 0, 0, 1, 8'h00, 8'h01, 0, 1, 8'h01); // 35 reset, empty ret
    add(1, 0, 1, 0, 2'd0, 0, 0, 0, 0, 8'h4F, 8'h4F, 0, 0, 8'h4F); // 36 reset, jump 4F
    add(0, 0, 0, 0, 2'd0, 0, 0, 1, 0, 8'h90, 8'h90, 1, 0, 8'h90); // 37 call pushes 50
    add(0, 1, 0, 0, 2'd0, 0, 0, 1, 0, 8'hA0, 8'hA0, 1, 0, 8'hA0); // 38 stalled call
    add(0, 0, 0, 0, 2'd0, 0, 0, 1, 1, 8'hA0, 8'h50, 0, 1, 8'hA0); // 39 call+ret
    add(0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 8'h00, 8'h51, 0, 1, 8'hA1); // 40 sequential

    rst_n = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0; br_mode = 2'd0;
    alu_zero = 1'b0; alu_neg = 1'b0; call = 1'b0; ret = 1'b0; immediate = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state(0);
    rst_n = 1'b1;
    #1;
    check_reset_state(0);
    exp_pc = 8'h00;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rb) begin
        // Reset between edges must act at once, with no clock edge.
        rst_n = 1'b0;
        #1;
        check_reset_state(i + 1);
        exp_pc = 8'h00;
        #1;
        rst_n = 1'b1;
      end
      @(negedge clk);
      stall = v.st; jump = v.jp; branch = v.br; br_mode = v.bm;
      alu_zero = v.z; alu_neg = v.ng; call = v.ca; ret = v.re; immediate = v.imm;
      #1;
      exp_nx = RAS_ON ? v.nx_on : v.nx_off;
      check("next_pc", i + 1, 32'(next_pc), 32'(exp_nx));
      if (!v.st) exp_pc = exp_nx;
      e.pc  = exp_pc;
      e.cnt = RAS_ON ? v.cnt_on : 3'd0;
      e.err = RAS_ON ? v.err_on : 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard (step %0d): got empty queue, expected an entry", i + 1);
      end else begin
        e = sb.pop_front();
        check("pc", i + 1, 32'(pc), 32'(e.pc));
        check("ras_count", i + 1, 32'(ras_count), 32'(e.cnt));
        check("ras_err", i + 1, 32'(ras_err), 32'(e.err));
        check("ras_full", i + 1, 32'(ras_full), 32'(e.cnt == 3'd4));
        check("ras_empty", i + 1, 32'(ras_empty), 32'(e.cnt == 3'd0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
